// File: rtl/pipe_skid_reg.sv
// Two-entry registered skid buffer used as a pipeline stage boundary.
// in_ready depends only on held state, so out_ready never reaches in_ready
// combinationally and stages can be chained without a ready-chain path.
module pipe_skid_reg #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state;
    logic               main_valid;
    logic               skid_valid;
    logic [WIDTH-1:0]   main_data;
    logic [WIDTH-1:0]   skid_data;
    logic               push;
    logic               pop;

    // Outputs come straight from registers; main always holds the oldest entry.
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign in_ready  = !skid_valid;
    assign count     = {1'b0, main_valid} + {1'b0, skid_valid};

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Occupancy state machine; flush squashes everything held (a push in the
    // flush cycle is dropped, a pop in the flush cycle is still delivered).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
        end else if (flush) begin
            state      <= EMPTY;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_data  <= in_data;
                        main_valid <= 1'b1;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (push && pop) begin
                        main_data <= in_data;
                    end else if (push) begin
                        skid_data  <= in_data;
                        skid_valid <= 1'b1;
                        state      <= FULL;
                    end else if (pop) begin
                        main_valid <= 1'b0;
                        state      <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        main_data  <= skid_data;
                        skid_valid <= 1'b0;
                        state      <= BUSY;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    main_valid <= 1'b0;
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios plus randomized traffic,
// compared each cycle against a queue-based FIFO model of depth two.
module tb_pipe_skid_reg;

    localparam int WIDTH = 64;

    logic             clk = 1'b0;
    logic             reset;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       count;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] q[$];

    pipe_skid_reg #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare DUT outputs with the model, then clock one cycle with the given inputs.
    // Called in the low clock phase.
    task automatic cycle(input logic v, input logic [WIDTH-1:0] d, input logic r, input logic f);
        int  n;
        bit  do_pop;
        bit  do_push;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        n = q.size();
        chk("out_valid", {63'd0, out_valid}, {63'd0, n > 0});
        chk("in_ready",  {63'd0, in_ready},  {63'd0, n < 2});
        chk("count",     {62'd0, count},     WIDTH'(n));
        if (n > 0) chk("out_data", out_data, q[0]);
        do_pop  = (n > 0) && r;
        do_push = v && (n < 2);
        @(posedge clk);
        if (f) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(d);
        end
        @(negedge clk);
    endtask

    initial begin
        logic             v;
        logic [WIDTH-1:0] d;
        logic             r;
        logic             f;
        bit               hold;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_count",     {62'd0, count},     64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("rst_out_data",  out_data,           64'd0);
        reset = 1'b0;

        // Fill, then reset asynchronously between edges while presenting 0xAA.
        cycle(1'b1, 64'h21, 1'b0, 1'b0);
        cycle(1'b1, 64'h22, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = 64'hAA; out_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_count",     {62'd0, count},     64'd0);
        chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("mid_rst_out_data",  out_data,           64'd0);
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b1, 64'h11, 1'b0, 1'b0);
        chk("first_push", out_data, 64'h11);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) cycle(1'b1, WIDTH'(i), 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Backpressure: A, B absorbed, C held, then drained in order
        cycle(1'b1, 64'h1, 1'b0, 1'b0);
        cycle(1'b1, 64'h2, 1'b0, 1'b0);
        cycle(1'b1, 64'h3, 1'b0, 1'b0);
        cycle(1'b1, 64'h3, 1'b0, 1'b0);
        cycle(1'b1, 64'h3, 1'b1, 1'b0);
        cycle(1'b1, 64'h3, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Simultaneous push and pop in BUSY
        cycle(1'b1, 64'h5, 1'b0, 1'b0);
        cycle(1'b1, 64'h6, 1'b1, 1'b0);
        chk("pp_main", out_data, 64'h6);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in FULL with push and pop in the same cycle
        cycle(1'b1, 64'h7, 1'b0, 1'b0);
        cycle(1'b1, 64'h8, 1'b0, 1'b0);
        chk("full_head", out_data, 64'h7);
        cycle(1'b1, 64'h9, 1'b1, 1'b1);
        chk("flush_empty", {63'd0, out_valid}, 64'd0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Flush in BUSY without push, then a fresh push
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 64'hC, 1'b1, 1'b0);
        chk("after_flush", out_data, 64'hC);
        cycle(1'b0, '0, 1'b1, 1'b0);
        // flush while EMPTY is a no-op
        cycle(1'b0, '0, 1'b1, 1'b1);

        // Randomized traffic; upstream holds a refused beat until it is taken.
        hold = 1'b0;
        v = 1'b0; d = '0;
        for (int k = 0; k < 2000; k++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                d = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 15) == 0);
            hold = v && (q.size() == 2) && !f;
            cycle(v, d, r, f);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
